// File: rtl/fft_stage_sequencer.sv
// Butterfly command sequencer for an in-place radix-2 DIT FFT over one shared datapath.
// Issues one (addr_a, addr_b, tw_idx) command per accepted cycle, with a drain gap between stages.
module fft_stage_sequencer #(
    parameter int LOG2N    = 6,
    parameter int BFLY_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             bfly_valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_idx,
    output logic [2:0]       stage,
    output logic             last_bfly,
    output logic             done
);
    localparam int DW = $clog2(BFLY_LAT + 1);
    localparam logic [LOG2N-2:0] J_LAST = '1;
    localparam logic [LOG2N-2:0] J_ONE  = 1;
    localparam logic [LOG2N-1:0] A_ONE  = 1;
    localparam logic [2:0]       S_LAST = 3'(LOG2N - 1);
    localparam logic [DW-1:0]    D_ONE  = 1;
    localparam logic [DW-1:0]    D_LOAD = DW'(BFLY_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [LOG2N-1:0] k;
    } cmd_t;

    state_t           state;
    logic [LOG2N-2:0] j;
    logic [DW-1:0]    drain;

    // Butterfly j of stage s: groups of 2^(s+1) words, partner 2^s apart.
    function automatic cmd_t gen_cmd(input logic [2:0] s, input logic [LOG2N-2:0] jj);
        logic [LOG2N-1:0] jw, mask, pos, grp;
        cmd_t c;
        jw   = {1'b0, jj};
        mask = (A_ONE << s) - A_ONE;
        pos  = jw & mask;
        grp  = jw >> s;
        c.a  = (grp << (s + 3'd1)) | pos;
        c.b  = c.a + (A_ONE << s);
        c.k  = pos << (S_LAST - s);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            bfly_valid <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            tw_idx     <= '0;
            stage      <= '0;
            last_bfly  <= 1'b0;
            done       <= 1'b0;
            j          <= '0;
            drain      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state                    <= S_RUN;
                        busy                     <= 1'b1;
                        bfly_valid               <= 1'b1;
                        stage                    <= '0;
                        j                        <= '0;
                        last_bfly                <= 1'b0;
                        {addr_a, addr_b, tw_idx} <= gen_cmd(3'd0, '0);
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (j == J_LAST) begin
                            state      <= S_DRAIN;
                            bfly_valid <= 1'b0;
                            last_bfly  <= 1'b0;
                            drain      <= D_LOAD;
                        end else begin
                            j                        <= j + J_ONE;
                            last_bfly                <= ((j + J_ONE) == J_LAST);
                            {addr_a, addr_b, tw_idx} <= gen_cmd(stage, j + J_ONE);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain == D_ONE) begin
                        if (stage == S_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state                    <= S_RUN;
                            stage                    <= stage + 3'd1;
                            j                        <= '0;
                            bfly_valid               <= 1'b1;
                            {addr_a, addr_b, tw_idx} <= gen_cmd(stage + 3'd1, '0);
                        end
                    end else begin
                        drain <= drain - D_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: scoreboard of expected butterfly commands plus cycle-exact checks.
module tb_fft_stage_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic       busy, bfly_valid, last_bfly, done;
    logic [5:0] addr_a, addr_b, tw_idx;
    logic [2:0] stage;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcount, dup;
    logic [63:0] cov [6];

    typedef struct {
        int s, a, b, k, last;
    } exp_t;
    exp_t sb[$];

    fft_stage_sequencer #(.LOG2N(6), .BFLY_LAT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy),
        .bfly_valid(bfly_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
        .stage(stage), .last_bfly(last_bfly), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected command stream built group by group, independent of the j-based formula.
    task automatic push_all();
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            int half = 1 << s;
            int ngrp = 32 >> s;
            for (int g = 0; g < ngrp; g++)
                for (int p = 0; p < half; p++) begin
                    e.s = s;
                    e.a = g * 2 * half + p;
                    e.b = e.a + half;
                    e.k = p * (32 / half);
                    e.last = (g == ngrp - 1 && p == half - 1) ? 1 : 0;
                    sb.push_back(e);
                end
        end
    endtask

    // Every command the consumer accepts is compared against the head of the scoreboard.
    always begin
        exp_t e;
        @(negedge clk);
        if (rst === 1'b0 && bfly_valid === 1'b1 && stall === 1'b0) begin
            vcount++;
            chk("tw_range", 32'(tw_idx < 6'd32), 1);
            if (sb.size() == 0) begin
                chk("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("sb_stage", stage, e.s);
                chk("sb_addr_a", addr_a, e.a);
                chk("sb_addr_b", addr_b, e.b);
                chk("sb_tw_idx", tw_idx, e.k);
                chk("sb_last", last_bfly, e.last);
            end
            if (stage < 3'd6) begin
                if (cov[stage][addr_a] || cov[stage][addr_b] || addr_a == addr_b) dup++;
                cov[stage][addr_a] = 1'b1;
                cov[stage][addr_b] = 1'b1;
            end
        end
    end

    task automatic run_xfer(input int exp_done, input bit with_stall, input bit ign);
        sb.delete();
        push_all();
        vcount = 0;
        dup = 0;
        for (int s = 0; s < 6; s++) cov[s] = '0;
        start = 1'b1;
        for (int n = 1; n <= exp_done + 6; n++) begin
            tick();
            chk("done_timing", done, 32'(n == exp_done));
            chk("busy_window", busy, 32'(n <= exp_done));
            if (n > exp_done) chk("idle_after_done", bfly_valid, 0);
            if (!with_stall) begin
                case (n)
                    1: begin
                        chk("first_valid", bfly_valid, 1);
                        chk("first_stage", stage, 0);
                        chk("first_a", addr_a, 0);
                        chk("first_b", addr_b, 1);
                        chk("first_k", tw_idx, 0);
                    end
                    2: begin chk("j1_a", addr_a, 2); chk("j1_b", addr_b, 3); chk("j1_k", tw_idx, 0); end
                    32: begin chk("j31_a", addr_a, 62); chk("j31_b", addr_b, 63); chk("j31_last", last_bfly, 1); end
                    33, 34, 35: chk("drain_gap", bfly_valid, 0);
                    76: begin
                        chk("s2j5_stage", stage, 2);
                        chk("s2j5_a", addr_a, 9); chk("s2j5_b", addr_b, 13); chk("s2j5_k", tw_idx, 8);
                    end
                    176: begin
                        chk("s5j0_stage", stage, 5);
                        chk("s5j0_a", addr_a, 0); chk("s5j0_b", addr_b, 32); chk("s5j0_k", tw_idx, 0);
                    end
                    177: begin chk("s5j1_a", addr_a, 1); chk("s5j1_b", addr_b, 33); chk("s5j1_k", tw_idx, 1); end
                    207: begin
                        chk("s5j31_a", addr_a, 31); chk("s5j31_b", addr_b, 63);
                        chk("s5j31_k", tw_idx, 31); chk("s5j31_last", last_bfly, 1);
                    end
                    default: ;
                endcase
            end else begin
                if (n >= 43 && n <= 47) begin
                    chk("stall_valid", bfly_valid, 1);
                    chk("stall_stage", stage, 1);
                    chk("stall_a", addr_a, 13);
                    chk("stall_b", addr_b, 15);
                    chk("stall_k", tw_idx, 16);
                end
                if (n == 48) begin
                    chk("post_stall_a", addr_a, 16); chk("post_stall_b", addr_b, 18); chk("post_stall_k", tw_idx, 0);
                end
            end
            start = ign && (n == 10 || n == 34 || n == exp_done);
            stall = with_stall && (n >= 43 && n <= 46);
        end
        start = 1'b0;
        stall = 1'b0;
        chk("sb_drained", sb.size(), 0);
        chk("valid_count", vcount, 192);
        chk("addr_dup", dup, 0);
        for (int s = 0; s < 6; s++) chk($sformatf("cover_stage%0d", s), 32'(cov[s] === '1), 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", bfly_valid, 0);
        chk("rst_a", addr_a, 0);
        chk("rst_b", addr_b, 0);
        chk("rst_k", tw_idx, 0);
        chk("rst_stage", stage, 0);
        chk("rst_last", last_bfly, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run_xfer(211, 1'b0, 1'b0);   // clean run
        run_xfer(215, 1'b1, 1'b0);   // 4-cycle stall at stage 1, j=7
        run_xfer(211, 1'b0, 1'b1);   // start pulses in RUN/DRAIN/DONE ignored
        repeat (3) tick();

        // abort during stage 3
        sb.delete();
        push_all();
        start = 1'b1;
        for (int n = 1; n <= 110; n++) begin
            tick();
            if (n == 1) begin chk("restart_stage", stage, 0); chk("restart_a", addr_a, 0); end
            if (n == 110) chk("pre_abort_stage", stage, 3);
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_valid", bfly_valid, 0);
        chk("abort_a", addr_a, 0);
        chk("abort_b", addr_b, 0);
        chk("abort_k", tw_idx, 0);
        chk("abort_stage", stage, 0);
        chk("abort_last", last_bfly, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        sb.delete();
        for (int n = 0; n < 120; n++) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_idle", bfly_valid, 0);
        end

        run_xfer(211, 1'b0, 1'b0);   // clean run after abort

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
